// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle CPU (Moore style).
// Walks each instruction through fetch/decode/execute/memory/writeback
// and drives the datapath enables, mux selects and register-file write
// controls. RegWre is held for the whole writeback cycle because the
// register file commits on the falling edge.
module multi_cycle_control #(
  parameter logic [5:0] OP_R    = 6'b000000,
  parameter logic [5:0] OP_LW   = 6'b100011,
  parameter logic [5:0] OP_SW   = 6'b101011,
  parameter logic [5:0] OP_BEQ  = 6'b000100,
  parameter logic [5:0] OP_ADDI = 6'b001000,
  parameter logic [5:0] OP_J    = 6'b000010,
  parameter logic [5:0] OP_HALT = 6'b111111
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic       IorD,
  output logic       MemRd,
  output logic       MemWr,
  output logic       IRWre,
  output logic       RegWre,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  state_e state_q, state_d;

  // Raw per-state controls before reset gating.
  logic pcwrite, branch;
  logic memwr_raw, irwre_raw, regwre_raw;

  // State register: reset returns to FETCH without waiting for a clock.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic: opcode steers DECODE and MEMADR; HALT is sticky.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_R)                state_d = S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else                                    state_d = S_HALT;
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode from current state; everything not named is 0.
  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    IorD       = 1'b0;
    MemRd      = 1'b0;
    memwr_raw  = 1'b0;
    irwre_raw  = 1'b0;
    regwre_raw = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRd     = 1'b1;
        irwre_raw = 1'b1;
        ALUSrcB   = 2'b01;
        pcwrite   = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD  = 1'b1;
        MemRd = 1'b1;
      end
      S_MEMWB: begin
        regwre_raw = 1'b1;
        MemToReg   = 1'b1;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        memwr_raw = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        regwre_raw = 1'b1;
        RegDst     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: regwre_raw = 1'b1;
      S_JUMP: begin
        PCSrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural write enables are masked by Reset so an abandoned
  // instruction can never commit, even mid-writeback.
  assign PCWre  = (pcwrite | (branch & zero)) & Reset;
  assign IRWre  = irwre_raw  & Reset;
  assign RegWre = regwre_raw & Reset;
  assign MemWr  = memwr_raw  & Reset;
  assign state  = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: directed instruction sequences followed
// by randomly chosen instructions, random zero flag and random
// mid-instruction resets, all checked against a per-instruction
// state-path reference and a per-state control table.
module tb_multi_cycle_control;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       PCWre, IorD, MemRd, MemWr, IRWre, RegWre, RegDst, MemToReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;

  int unsigned tests = 0;
  int unsigned failed = 0;

  localparam logic [5:0] R_OP    = 6'b000000;
  localparam logic [5:0] LW_OP   = 6'b100011;
  localparam logic [5:0] SW_OP   = 6'b101011;
  localparam logic [5:0] BEQ_OP  = 6'b000100;
  localparam logic [5:0] ADDI_OP = 6'b001000;
  localparam logic [5:0] J_OP    = 6'b000010;
  localparam logic [5:0] HALT_OP = 6'b111111;

  multi_cycle_control dut (
    .clock(clock), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr),
    .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pcwre, iord, memrd, memwr, irwre, regwre, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
  } ctl_t;

  // Control table: what each named step of an instruction asserts.
  function automatic ctl_t expect_ctl(input int st, input logic z, input logic in_reset);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.memrd = 1; c.irwre = 1; c.alusrcb = 2'b01; c.pcwre = 1; end
      1:  c.alusrcb = 2'b11;
      2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      3:  begin c.iord = 1; c.memrd = 1; end
      4:  begin c.regwre = 1; c.memtoreg = 1; end
      5:  begin c.iord = 1; c.memwr = 1; end
      6:  begin c.alusrca = 1; c.aluop = 2'b10; end
      7:  begin c.regwre = 1; c.regdst = 1; end
      8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcwre = z; end
      9:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      10: c.regwre = 1;
      11: begin c.pcsrc = 2'b10; c.pcwre = 1; end
      default: ;
    endcase
    if (in_reset) begin
      c.pcwre = 0; c.irwre = 0; c.regwre = 0; c.memwr = 0;
    end
    return c;
  endfunction

  // Reference: the sequence of steps an instruction walks through.
  function automatic void build_path(input logic [5:0] op, output int p[$]);
    p = {};
    case (op)
      LW_OP:   p = '{0, 1, 2, 3, 4};
      SW_OP:   p = '{0, 1, 2, 5};
      R_OP:    p = '{0, 1, 6, 7};
      BEQ_OP:  p = '{0, 1, 8};
      ADDI_OP: p = '{0, 1, 9, 10};
      J_OP:    p = '{0, 1, 11};
      default: p = '{0, 1, 12};
    endcase
  endfunction

  // zmode: 0/1 force zero, 2 = random.
  task automatic check(input string tag, input int exp_st, input logic in_reset, input int zmode);
    ctl_t act, exp;
    zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
    #1;
    act = {PCWre, IorD, MemRd, MemWr, IRWre, RegWre, RegDst, MemToReg, ALUSrcA,
           ALUSrcB, ALUOp, PCSrc};
    exp = expect_ctl(exp_st, zero, in_reset);
    tests++;
    assert (state === 4'(exp_st)) else begin
      failed++;
      $error("FAIL %s state: got %0d expected %0d", tag, state, exp_st);
    end
    tests++;
    assert (act === exp) else begin
      failed++;
      $error("FAIL %s ctl (st %0d z %0b): got %b expected %b", tag, exp_st, zero, act, exp);
    end
    tests++;
    assert (!(RegWre === 1'b1 && MemWr === 1'b1)) else begin
      failed++;
      $error("FAIL %s regwre_memwr: got both 1 expected not both", tag);
    end
    tests++;
    assert (!(IRWre === 1'b1 && state !== 4'd0)) else begin
      failed++;
      $error("FAIL %s irwre_outside_fetch: got IRWre=1 in state %0d expected 0", tag, state);
    end
  endtask

  // Asynchronous reset in the middle of a cycle, then release on negedge.
  task automatic async_reset(input string tag);
    #1 Reset = 1'b0;
    check({tag, "_rst"}, 0, 1'b1, 2);
    @(negedge clock);
    Reset = 1'b1;
  endtask

  // Runs one instruction from FETCH; leaves the DUT back in FETCH.
  // reset_at >= 1 abandons the instruction at that step.
  task automatic run_instr(input logic [5:0] op, input int zmode, input int reset_at, input string tag);
    int p[$];
    build_path(op, p);
    opcode = op;
    for (int i = 0; i < p.size(); i++) begin
      if (i > 0) begin
        @(posedge clock);
        #1;
      end
      check(tag, p[i], 1'b0, zmode);
      if (i == reset_at) begin
        async_reset(tag);
        return;
      end
    end
    if (p[p.size()-1] == 12) begin
      for (int k = 0; k < 22; k++) begin
        @(posedge clock);
        #1;
        opcode = 6'($urandom);
        check({tag, "_hold"}, 12, 1'b0, 2);
      end
      async_reset({tag, "_halt"});
      return;
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [5:0] undefined_op();
    logic [5:0] o;
    do o = 6'($urandom);
    while (o == R_OP || o == LW_OP || o == SW_OP || o == BEQ_OP ||
           o == ADDI_OP || o == J_OP || o == HALT_OP);
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ops [8];
    int len, rst_at, r;
    ops = '{R_OP, LW_OP, SW_OP, BEQ_OP, ADDI_OP, J_OP, R_OP, LW_OP};

    // Reset held from time zero.
    #2;
    check("reset", 0, 1'b1, 2);
    @(negedge clock);
    Reset = 1'b1;

    // Directed sequences.
    run_instr(LW_OP,   2, -1, "lw");
    run_instr(R_OP,    2, -1, "r");
    run_instr(BEQ_OP,  1, -1, "beq_z1");
    run_instr(BEQ_OP,  0, -1, "beq_z0");
    run_instr(SW_OP,   2, -1, "sw");
    run_instr(ADDI_OP, 2, -1, "addi");
    run_instr(J_OP,    2, -1, "j");
    run_instr(R_OP,    2,  3, "r_rst_aluwb");
    run_instr(LW_OP,   2,  4, "lw_rst_memwb");
    run_instr(ADDI_OP, 2,  3, "addi_rst_wb");
    run_instr(HALT_OP, 2, -1, "halt");
    run_instr(6'b010101, 2, -1, "undef");

    // Random instruction stream.
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r < 16) begin
        len = (ops[r % 8] == LW_OP) ? 5 :
              (ops[r % 8] == BEQ_OP || ops[r % 8] == J_OP) ? 3 : 4;
        rst_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, len - 1)) : -1;
        run_instr(ops[r % 8], 2, rst_at, "rnd");
      end else if (r < 18) begin
        run_instr(HALT_OP, 2, -1, "rnd_halt");
      end else begin
        run_instr(undefined_op(), 2, -1, "rnd_undef");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
